// File: rtl/msi_directory_ctrl.sv
// MSI directory controller for the shared L2 list.
// One processor request is serviced at a time: lookup, optional invalidate or
// downgrade of other holders, optional victim writeback, optional memory fill,
// then a single-cycle response. Entry storage lives in msi_dir_entry instances.

// One directory entry: state registers plus its own address compare.
module msi_dir_entry #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int NUM_PROCS = 2
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 wrEn,
  input  logic [ADDR_W-1:0]    wrAddr,
  input  logic [1:0]           wrState,
  input  logic [DATA_W-1:0]    wrData,
  input  logic [NUM_PROCS-1:0] wrSharers,
  input  logic [ADDR_W-1:0]    lookupAddr,
  output logic                 valid,
  output logic [ADDR_W-1:0]    addr,
  output logic [1:0]           state,
  output logic [DATA_W-1:0]    data,
  output logic [NUM_PROCS-1:0] sharers,
  output logic                 hit
);

  // Entry contents; reset leaves the entry invalid in state I with no sharers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      valid   <= 1'b0;
      addr    <= '0;
      state   <= 2'b01;
      data    <= '0;
      sharers <= '0;
    end else if (wrEn) begin
      valid   <= 1'b1;
      addr    <= wrAddr;
      state   <= wrState;
      data    <= wrData;
      sharers <= wrSharers;
    end
  end

  // Address 0 is reserved, so it can never produce a hit.
  always_comb begin
    hit = valid && (state != 2'b01) && (addr == lookupAddr) && (lookupAddr != '0);
  end

endmodule

module msi_directory_ctrl #(
  parameter int NUM_ENTRIES = 4,
  parameter int NUM_PROCS   = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  localparam int PW = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [PW-1:0]        ReqProc,
  input  logic                 ReqWrite,
  input  logic [ADDR_W-1:0]    ReqAddr,
  input  logic [DATA_W-1:0]    ReqData,
  output logic                 RespValid,
  output logic [DATA_W-1:0]    RespData,
  output logic [1:0]           RespState,
  output logic                 InvValid,
  output logic                 InvDowngrade,
  output logic [NUM_PROCS-1:0] InvMask,
  input  logic [NUM_PROCS-1:0] InvAck,
  output logic                 MemRdValid,
  output logic                 MemWrValid,
  output logic [ADDR_W-1:0]    MemAddr,
  output logic [DATA_W-1:0]    MemWrData,
  input  logic                 MemRdDone,
  input  logic [DATA_W-1:0]    MemRdData
);

  localparam logic [1:0] ST_I = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, EVICT, FILL, RESP} fsm_e;

  typedef struct packed {
    logic [PW-1:0]     proc;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  fsm_e fsmState, fsmNext;
  req_t req;

  logic [NUM_ENTRIES-1:0]                eValid;
  logic [NUM_ENTRIES-1:0][ADDR_W-1:0]    eAddr;
  logic [NUM_ENTRIES-1:0][1:0]           eState;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0]    eData;
  logic [NUM_ENTRIES-1:0][NUM_PROCS-1:0] eSharers;
  logic [NUM_ENTRIES-1:0]                eHit;
  logic [NUM_ENTRIES-1:0]                entryWr;

  logic [NUM_PROCS-1:0] reqBit;
  logic                 hitAny, freeAny;
  logic [IW-1:0]        hitIdx, freeIdx;

  fsm_e                 lkNext;
  logic [IW-1:0]        lkIdx;
  logic [NUM_PROCS-1:0] lkMask;
  logic                 lkDown, lkEvict;

  logic [IW-1:0]        tgtIdx, victimPtr, selIdx;
  logic                 tgtHit, selHit;
  logic [NUM_PROCS-1:0] pending, invMaskR;
  logic                 invDownR, rdIssued;

  logic [1:0]           finState;
  logic [NUM_PROCS-1:0] finSharers;
  logic [DATA_W-1:0]    finData;
  logic                 enterResp;
  logic [DATA_W-1:0]    respDataR;
  logic [1:0]           respStateR;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : gEntry
    msi_dir_entry #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_PROCS(NUM_PROCS)
    ) uEntry (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .wrEn      (entryWr[i]),
      .wrAddr    (req.addr),
      .wrState   (finState),
      .wrData    (finData),
      .wrSharers (finSharers),
      .lookupAddr(req.addr),
      .valid     (eValid[i]),
      .addr      (eAddr[i]),
      .state     (eState[i]),
      .data      (eData[i]),
      .sharers   (eSharers[i]),
      .hit       (eHit[i])
    );
  end

  assign reqBit = NUM_PROCS'(1) << req.proc;

  // Lowest-index hit and lowest-index free slot (descending scan so low wins).
  always_comb begin
    hitAny  = 1'b0;
    hitIdx  = '0;
    freeAny = 1'b0;
    freeIdx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (eHit[i]) begin
        hitAny = 1'b1;
        hitIdx = IW'(i);
      end
      if (!eValid[i] || eState[i] == ST_I) begin
        freeAny = 1'b1;
        freeIdx = IW'(i);
      end
    end
  end

  // Lookup decision: which entry is targeted and what coherence work precedes the response.
  always_comb begin
    lkNext  = RESP;
    lkIdx   = hitIdx;
    lkMask  = '0;
    lkDown  = 1'b0;
    lkEvict = 1'b0;
    if (hitAny) begin
      if (!req.write) begin
        // Read of a block modified by someone else: owner drops to S.
        if (eState[hitIdx] == ST_M && (eSharers[hitIdx] & reqBit) == '0) begin
          lkNext = INVAL;
          lkMask = eSharers[hitIdx];
          lkDown = 1'b1;
        end
      end else if ((eSharers[hitIdx] & ~reqBit) != '0) begin
        lkNext = INVAL;
        lkMask = eSharers[hitIdx] & ~reqBit;
      end
    end else if (freeAny) begin
      lkIdx = freeIdx;
      if (req.write) lkNext = RESP;
      else           lkNext = FILL;
    end else begin
      lkIdx   = victimPtr;
      lkNext  = EVICT;
      lkMask  = eSharers[victimPtr];
      lkEvict = 1'b1;
    end
  end

  // Values installed into the target entry and reported on the response.
  always_comb begin
    selIdx     = (fsmState == LOOKUP) ? lkIdx  : tgtIdx;
    selHit     = (fsmState == LOOKUP) ? hitAny : tgtHit;
    finState   = ST_M;
    finSharers = reqBit;
    finData    = req.data;
    if (!req.write) begin
      if (selHit) begin
        finSharers = eSharers[selIdx] | reqBit;
        finData    = eData[selIdx];
        if (eState[selIdx] == ST_M && (eSharers[selIdx] & reqBit) == '0) finState = ST_S;
        else                                                             finState = eState[selIdx];
      end else begin
        finState = ST_S;
        finData  = MemRdData;
      end
    end
    enterResp = (fsmNext == RESP) && (fsmState != RESP);
    entryWr   = enterResp ? (NUM_ENTRIES'(1) << selIdx) : '0;
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) fsmState <= IDLE;
    else         fsmState <= fsmNext;
  end

  // FSM next-state logic.
  always_comb begin
    fsmNext = fsmState;
    case (fsmState)
      IDLE:    if (ReqValid) fsmNext = LOOKUP;
      LOOKUP:  fsmNext = lkNext;
      INVAL:   if (pending == '0) fsmNext = RESP;
      EVICT:   if (pending == '0) begin
                 if (req.write) fsmNext = RESP;
                 else           fsmNext = FILL;
               end
      FILL:    if (MemRdDone) fsmNext = RESP;
      RESP:    fsmNext = IDLE;
      default: fsmNext = IDLE;
    endcase
  end

  // Request latch, target bookkeeping, ack collection and held response fields.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      req        <= '0;
      tgtIdx     <= '0;
      tgtHit     <= 1'b0;
      victimPtr  <= '0;
      pending    <= '0;
      invMaskR   <= '0;
      invDownR   <= 1'b0;
      rdIssued   <= 1'b0;
      respDataR  <= '0;
      respStateR <= '0;
    end else begin
      if (fsmState == IDLE && ReqValid)
        req <= '{proc: ReqProc, write: ReqWrite, addr: ReqAddr, data: ReqData};
      if (fsmState == LOOKUP) begin
        tgtIdx   <= lkIdx;
        tgtHit   <= hitAny;
        pending  <= lkMask;
        invMaskR <= lkMask;
        invDownR <= lkDown;
        if (lkEvict)
          victimPtr <= (victimPtr == IW'(NUM_ENTRIES - 1)) ? '0 : victimPtr + 1'b1;
      end else if (fsmState == INVAL || fsmState == EVICT) begin
        // Acks from processors outside the mask cannot clear anything.
        pending <= pending & ~InvAck;
      end
      rdIssued <= (fsmState == FILL);
      if (enterResp) begin
        respDataR  <= finData;
        respStateR <= finState;
      end
    end
  end

  // FSM-derived outputs; the victim's entry is untouched until RESP, so it sources the writeback.
  always_comb begin
    ReqReady     = (fsmState == IDLE);
    RespValid    = (fsmState == RESP);
    InvValid     = (fsmState == INVAL || fsmState == EVICT) && (pending != '0);
    InvMask      = InvValid ? invMaskR : '0;
    InvDowngrade = InvValid && invDownR;
    MemWrValid   = (fsmState == EVICT) && (pending == '0) && (eState[tgtIdx] == ST_M);
    MemRdValid   = (fsmState == FILL) && !rdIssued;
    MemAddr      = '0;
    MemWrData    = '0;
    if (MemRdValid) begin
      MemAddr = req.addr;
    end else if (MemWrValid) begin
      MemAddr   = eAddr[tgtIdx];
      MemWrData = eData[tgtIdx];
    end
  end

  assign RespData  = respDataR;
  assign RespState = respStateR;

endmodule

// File: tb/tb_msi_directory_ctrl.sv
// Self-checking bench for msi_directory_ctrl: directed scenarios followed by
// random traffic, all compared against a block-level MSI directory model.
module tb_msi_directory_ctrl;

  localparam int NE = 4;
  localparam int NP = 2;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int PW = 1;
  localparam int ST_I = 1;
  localparam int ST_S = 2;
  localparam int ST_M = 3;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          ReqValid, ReqReady, ReqWrite;
  logic [PW-1:0] ReqProc;
  logic [AW-1:0] ReqAddr;
  logic [DW-1:0] ReqData;
  logic          RespValid;
  logic [DW-1:0] RespData;
  logic [1:0]    RespState;
  logic          InvValid, InvDowngrade;
  logic [NP-1:0] InvMask, InvAck;
  logic          MemRdValid, MemWrValid, MemRdDone;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData, MemRdData;

  msi_directory_ctrl #(.NUM_ENTRIES(NE), .NUM_PROCS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqProc(ReqProc), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RespValid(RespValid), .RespData(RespData), .RespState(RespState),
    .InvValid(InvValid), .InvDowngrade(InvDowngrade), .InvMask(InvMask), .InvAck(InvAck),
    .MemRdValid(MemRdValid), .MemWrValid(MemWrValid), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemRdDone(MemRdDone), .MemRdData(MemRdData)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Directory model: one record per entry plus the round-robin victim pointer.
  bit mValid[NE];
  int mAddr[NE], mSt[NE], mData[NE], mSh[NE];
  int mPtr;

  // Predicted side effects of the current request.
  int expInv, expInvMask, expInvDown, expWr, expWrAddr, expWrData, expRd;
  int expData, expState, expFast, expHitInv;
  int lastData, lastState;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NE; i++) begin
      mValid[i] = 0; mAddr[i] = 0; mSt[i] = ST_I; mData[i] = 0; mSh[i] = 0;
    end
    mPtr = 0;
  endtask

  // Apply one request to the model and record what the controller must do.
  task automatic modelReq(input int p, input int w, input int a, input int d, input int fill);
    int idx, pb;
    pb = 1 << p;
    expInv = 0; expInvMask = 0; expInvDown = 0; expWr = 0; expWrAddr = 0; expWrData = 0;
    expRd = 0; expHitInv = 0;
    idx = -1;
    for (int i = 0; i < NE; i++)
      if (idx < 0 && mValid[i] && mAddr[i] == a && mSt[i] != ST_I) idx = i;
    if (idx >= 0) begin
      if (w == 0) begin
        if (mSt[idx] == ST_M && (mSh[idx] & pb) == 0) begin
          expInv = 1; expInvMask = mSh[idx]; expInvDown = 1; mSt[idx] = ST_S;
        end
        mSh[idx] = mSh[idx] | pb;
      end else begin
        if ((mSh[idx] & ~pb) != 0) begin
          expInv = 1; expInvMask = mSh[idx] & ~pb;
        end
        mSt[idx] = ST_M; mSh[idx] = pb; mData[idx] = d;
      end
      expHitInv = expInv;
    end else begin
      for (int i = 0; i < NE; i++)
        if (idx < 0 && !mValid[i]) idx = i;
      if (idx < 0) begin
        idx = mPtr;
        mPtr = (mPtr + 1) % NE;
        if (mSh[idx] != 0) begin expInv = 1; expInvMask = mSh[idx]; end
        if (mSt[idx] == ST_M) begin expWr = 1; expWrAddr = mAddr[idx]; expWrData = mData[idx]; end
      end
      mValid[idx] = 1; mAddr[idx] = a; mSh[idx] = pb;
      if (w != 0) begin mSt[idx] = ST_M; mData[idx] = d; end
      else begin mSt[idx] = ST_S; mData[idx] = fill; expRd = 1; end
    end
    expFast  = (expInv == 0 && expWr == 0 && expRd == 0) ? 1 : 0;
    expData  = mData[idx];
    expState = mSt[idx];
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_ready"}, ReqReady, 1);
    chk({tag, "_resp"}, {RespValid, RespData, RespState}, 0);
    chk({tag, "_inv"}, {InvValid, InvDowngrade, InvMask}, 0);
    chk({tag, "_mem"}, {MemRdValid, MemWrValid, MemAddr, MemWrData}, 0);
  endtask

  // Issue one request and act as caches and memory until the response arrives.
  task automatic doTxn(input int p, input int w, input int a, input int d, input int fill);
    int cyc, zc, wrCnt, rdCnt, rdAt, respCyc, pendTb;
    int ackAt[NP];
    bit seenInv, done;
    modelReq(p, w, a, d, fill);
    @(negedge Clock);
    chk("hold_data", RespData, lastData);
    chk("hold_state", RespState, lastState);
    chk("req_ready", ReqReady, 1);
    InvAck = '0; MemRdDone = 1'b0; MemRdData = DW'(fill);
    ReqValid = 1'b1; ReqProc = PW'(p); ReqWrite = w[0]; ReqAddr = AW'(a); ReqData = DW'(d);
    cyc = 0; zc = -1; wrCnt = 0; rdCnt = 0; rdAt = -1; respCyc = -1; pendTb = 0;
    seenInv = 0; done = 0;
    for (int b = 0; b < NP; b++) ackAt[b] = -1;
    while (!done && cyc < 200) begin
      @(negedge Clock);
      cyc++;
      ReqValid = 1'b0; InvAck = '0; MemRdDone = 1'b0;
      if (InvValid && !seenInv) begin
        seenInv = 1;
        pendTb  = expInvMask;
        chk("inv_mask", InvMask, expInvMask);
        chk("inv_down", InvDowngrade, expInvDown);
        for (int b = 0; b < NP; b++)
          if (expInvMask[b]) ackAt[b] = cyc + $urandom_range(0, 3);
      end
      if (seenInv) begin
        chk("inv_hold", InvValid, pendTb != 0);
        if (pendTb == 0 && zc < 0) zc = cyc;
      end
      for (int b = 0; b < NP; b++)
        if (ackAt[b] == cyc) begin InvAck[b] = 1'b1; pendTb = pendTb & ~(1 << b); end
      if ($urandom_range(0, 3) == 0)
        InvAck = InvAck | (NP'($urandom_range(0, (1 << NP) - 1)) & ~NP'(expInvMask));
      if (MemWrValid) begin
        wrCnt++;
        chk("wr_addr", MemAddr, expWrAddr);
        chk("wr_data", MemWrData, expWrData);
        chk("wr_at", cyc, zc);
      end
      if (MemRdValid) begin
        rdCnt++;
        chk("rd_addr", MemAddr, a);
        rdAt = cyc + $urandom_range(0, 4);
      end
      if (rdAt == cyc) MemRdDone = 1'b1;
      if (RespValid) begin
        done = 1; respCyc = cyc;
        chk("resp_data", RespData, expData);
        chk("resp_state", RespState, expState);
      end
    end
    chk("resp_seen", done, 1);
    chk("inv_seen", seenInv, expInv);
    chk("wr_cnt", wrCnt, expWr);
    chk("rd_cnt", rdCnt, expRd);
    if (done && expFast != 0)   chk("lat_fast", respCyc, 2);
    if (done && expHitInv != 0) chk("lat_inval", respCyc, zc + 1);
    lastData = expData; lastState = expState;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Resetn = 1'b0; ReqValid = 1'b0; ReqProc = '0; ReqWrite = 1'b0; ReqAddr = '0; ReqData = '0;
    InvAck = '0; MemRdDone = 1'b0; MemRdData = '0;
    modelReset(); lastData = 0; lastState = 0;
    #12;
    chkIdle("rst");
    @(negedge Clock);
    Resetn = 1'b1;

    // Read miss fills from memory, then a second reader shares it.
    doTxn(0, 0, 1, 0, 2);
    doTxn(1, 0, 1, 0, $urandom_range(0, 15));
    // Write with another sharer, then a read that downgrades the owner.
    doTxn(1, 1, 1, 9, $urandom_range(0, 15));
    doTxn(0, 0, 1, 0, $urandom_range(0, 15));
    // Fill the remaining entries, re-own entry0, then force eviction of dirty entry0.
    doTxn(0, 0, 2, 0, $urandom_range(0, 15));
    doTxn(0, 0, 3, 0, $urandom_range(0, 15));
    doTxn(0, 0, 4, 0, $urandom_range(0, 15));
    doTxn(1, 1, 1, 9, $urandom_range(0, 15));
    doTxn(0, 1, 5, 3, $urandom_range(0, 15));
    // Victim pointer has moved on to entry1 (clean, shared by P0).
    doTxn(1, 1, 6, 7, $urandom_range(0, 15));

    // Reset while the controller waits for an invalidation ack.
    @(negedge Clock);
    ReqValid = 1'b1; ReqProc = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'd3; ReqData = 4'd5; InvAck = '0;
    n = 0;
    do begin
      @(negedge Clock);
      ReqValid = 1'b0;
      n++;
    end while (!InvValid && n < 20);
    chk("midop_inv", InvValid, 1);
    chk("midop_mask", InvMask, 1);
    repeat (2) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1 chkIdle("midrst");
    @(negedge Clock);
    Resetn = 1'b1;
    modelReset(); lastData = 0; lastState = 0;
    // Previously cached block must miss after reset.
    doTxn(0, 0, 1, 0, 6);

    for (int t = 0; t < 400; t++)
      doTxn($urandom_range(0, NP - 1), $urandom_range(0, 1), $urandom_range(1, 7),
            $urandom_range(0, 15), $urandom_range(0, 15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
